// File: rtl/hdc_mem_pkg.sv
// Shared types for the HDC hypervector memory path.
// Word/address widths match the sky130_sram_64x32 macro.
package hdc_mem_pkg;

  localparam int HV_WORD_W = 64;
  localparam int HV_ADDR_W = 5;

  typedef logic [HV_WORD_W-1:0] hv_word_t;
  typedef logic [HV_ADDR_W-1:0] hv_addr_t;

  typedef enum logic {
    IDLE,
    CLEAR
  } sram_ctrl_state_e;

endpackage

// File: rtl/hv_rr_arb2.sv
// Two-requester round-robin arbiter (write vs read).
// Registered last-grant; after reset a conflict goes to the write.
module hv_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req_wr,
  input  logic i_req_rd,
  output logic o_gnt_wr,
  output logic o_gnt_rd
);

  logic r_last_rd;
  logic w_gnt_wr;
  logic w_gnt_rd;

  assign w_gnt_wr = i_req_wr && (!i_req_rd || r_last_rd);
  assign w_gnt_rd = i_req_rd && (!i_req_wr || !r_last_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_rd <= 1'b1;
    end else if (w_gnt_wr) begin
      r_last_rd <= 1'b0;
    end else if (w_gnt_rd) begin
      r_last_rd <= 1'b1;
    end
  end

  assign o_gnt_wr = w_gnt_wr;
  assign o_gnt_rd = w_gnt_rd;

endmodule

// File: rtl/hv_sram_ctrl.sv
// Single-port access controller for one sky130_sram_64x32 macro.
// Optional perf counters: define HV_SRAM_CTRL_PERF_EN.
module hv_sram_ctrl
  import hdc_mem_pkg::*;
#(
  parameter int DATA_WIDTH = HV_WORD_W,
  parameter int ADDR_WIDTH = HV_ADDR_W,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  clr_start,
  output logic                  busy,
  output logic                  clr_done,
`ifdef HV_SRAM_CTRL_PERF_EN
  output logic [31:0]           perf_wr_cnt,
  output logic [31:0]           perf_rd_cnt,
`endif
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  localparam logic [ADDR_WIDTH-1:0] LP_LAST =
    ADDR_WIDTH'(RAM_DEPTH - 1);

  sram_ctrl_state_e r_state;
  sram_ctrl_state_e w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_din;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic                  w_idle;
  logic                  w_busy;
  logic                  w_last;
  logic                  w_open;
  logic                  w_slot_free;
  logic                  w_wr_elig;
  logic                  w_rd_elig;
  logic                  w_gnt_wr;
  logic                  w_gnt_rd;
  logic                  w_csb;
  logic                  w_web;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_din;

  assign w_idle = (r_state == IDLE);
  assign w_busy = (r_state == CLEAR);
  assign w_last = w_busy && (r_cnt == LP_LAST);

  // Gate on rst_n so the macro stays deselected while reset is held.
  assign w_open      = rst_n && w_idle && !clr_start;
  assign w_slot_free = !r_rd_valid || rd_ready;
  assign w_wr_elig   = w_open && wr_valid;
  assign w_rd_elig   = w_open && rd_req_valid && w_slot_free;

  hv_rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req_wr (w_wr_elig),
    .i_req_rd (w_rd_elig),
    .o_gnt_wr (w_gnt_wr),
    .o_gnt_rd (w_gnt_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (clr_start) begin
          w_state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        if (w_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_csb  = 1'b1;
    w_web  = 1'b1;
    w_addr = r_addr;
    w_din  = r_din;
    unique case (1'b1)
      w_busy: begin
        w_csb  = 1'b0;
        w_web  = 1'b0;
        w_addr = r_cnt;
        w_din  = '0;
      end
      w_gnt_wr: begin
        w_csb  = 1'b0;
        w_web  = 1'b0;
        w_addr = wr_addr;
        w_din  = wr_data;
      end
      w_gnt_rd: begin
        w_csb  = 1'b0;
        w_addr = rd_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_din  <= '0;
    end else begin
      r_addr <= w_addr;
      r_din  <= w_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_idle) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else if (w_gnt_rd) begin
      r_rd_valid <= 1'b1;
      r_rd_data  <= sram_dout;
    end else if (rd_ready) begin
      r_rd_valid <= 1'b0;
    end
  end

`ifdef HV_SRAM_CTRL_PERF_EN
  logic [31:0] r_perf_wr;
  logic [31:0] r_perf_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_wr <= '0;
      r_perf_rd <= '0;
    end else begin
      if (w_gnt_wr && (r_perf_wr != '1)) begin
        r_perf_wr <= r_perf_wr + 32'd1;
      end
      if (w_gnt_rd && (r_perf_rd != '1)) begin
        r_perf_rd <= r_perf_rd + 32'd1;
      end
    end
  end

  assign perf_wr_cnt = r_perf_wr;
  assign perf_rd_cnt = r_perf_rd;
`endif

  assign wr_ready     = w_gnt_wr;
  assign rd_req_ready = w_gnt_rd;
  assign rd_valid     = r_rd_valid;
  assign rd_data      = r_rd_data;
  assign busy         = w_busy;
  assign clr_done     = w_last;
  assign sram_csb     = w_csb;
  assign sram_web     = w_web;
  assign sram_addr    = w_addr;
  assign sram_din     = w_din;

endmodule

// File: tb/tb_hv_sram_ctrl.sv
// Scoreboard bench for hv_sram_ctrl with a behavioural SRAM macro.
// Build with HV_SRAM_CTRL_PERF_EN to also cover the perf counters.
module tb_hv_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [4:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        rd_req_valid = 1'b0;
  logic        rd_req_ready;
  logic [4:0]  rd_addr = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [63:0] rd_data;
  logic        clr_start = 1'b0;
  logic        busy;
  logic        clr_done;
  logic        sram_csb;
  logic        sram_web;
  logic [4:0]  sram_addr;
  logic [63:0] sram_din;
  logic [63:0] sram_dout;
`ifdef HV_SRAM_CTRL_PERF_EN
  logic [31:0] perf_wr_cnt;
  logic [31:0] perf_rd_cnt;
`endif

  int n_checks = 0;
  int n_pass = 0;

  logic [63:0] mem [32];
  logic [63:0] ref_mem [32];
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  hv_sram_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_addr      (rd_addr),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .clr_start    (clr_start),
    .busy         (busy),
    .clr_done     (clr_done),
`ifdef HV_SRAM_CTRL_PERF_EN
    .perf_wr_cnt  (perf_wr_cnt),
    .perf_rd_cnt  (perf_rd_cnt),
`endif
    .sram_csb     (sram_csb),
    .sram_web     (sram_web),
    .sram_addr    (sram_addr),
    .sram_din     (sram_din),
    .sram_dout    (sram_dout)
  );

  // Macro model: combinational read, write committed on negedge.
  assign sram_dout = mem[sram_addr];
  always @(negedge clk) begin
    if (!sram_csb && !sram_web) mem[sram_addr] <= sram_din;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: the array as seen through accepted transactions.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          chk("rsp_data", rd_data, exp_q.pop_front());
        end
      end
      if (clr_start && !busy) begin
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
      end
      if (wr_valid && wr_ready) ref_mem[wr_addr] = wr_data;
      if (rd_req_valid && rd_req_ready) exp_q.push_back(ref_mem[rd_addr]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_valid = 1'b0;
    rd_req_valid = 1'b0;
    rd_ready = 1'b0;
    clr_start = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [63:0] d);
    logic got;
    got = 1'b0;
    wr_valid = 1'b1;
    wr_addr = a;
    wr_data = d;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = wr_ready;
      tick();
    end
    wr_valid = 1'b0;
    if (!got) chk("wr_accept_timeout", {63'd0, got}, 64'd1);
  endtask

  task automatic do_read(input logic [4:0] a);
    logic got;
    got = 1'b0;
    rd_req_valid = 1'b1;
    rd_addr = a;
    rd_ready = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = rd_req_ready;
      tick();
    end
    rd_req_valid = 1'b0;
    if (!got) chk("rd_accept_timeout", {63'd0, got}, 64'd1);
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
      tick();
    end
  endtask

  initial begin
    int nb;
    int nd;
    int addr_at_done;
    int wr_hits;
    int rd_hits;
    logic [1:0] seq [4];
    logic hit10;

    for (int i = 0; i < 32; i++) begin
      mem[i] = {$urandom, $urandom};
      ref_mem[i] = mem[i];
    end

    #2;
    chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_clr_done", {63'd0, clr_done}, 64'd0);
    chk("rst_csb", {63'd0, sram_csb}, 64'd1);
    chk("rst_web", {63'd0, sram_web}, 64'd1);
    chk("rst_addr", {59'd0, sram_addr}, 64'd0);
    chk("rst_din", sram_din, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Write then read the same word.
    do_write(5'd3, 64'hDEADBEEF_00000001);
    rd_req_valid = 1'b1;
    rd_addr = 5'd3;
    rd_ready = 1'b1;
    @(negedge clk);
    chk("wr_rd_acc", {63'd0, rd_req_ready}, 64'd1);
    tick();
    rd_req_valid = 1'b0;
    @(negedge clk);
    chk("wr_rd_lat", {63'd0, rd_valid}, 64'd1);
    chk("wr_rd_data", rd_data, 64'hDEADBEEF_00000001);
    tick();
    tick();

    // Conflict alternation right after a fresh reset.
    do_reset();
    wr_valid = 1'b1;
    wr_addr = 5'd5;
    wr_data = {$urandom, $urandom};
    rd_req_valid = 1'b1;
    rd_addr = 5'd6;
    rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seq[k] = {wr_ready, rd_req_ready};
      tick();
      wr_data = {$urandom, $urandom};
    end
    wr_valid = 1'b0;
    rd_req_valid = 1'b0;
    chk("arb_0_w", {62'd0, seq[0]}, 64'd2);
    chk("arb_1_r", {62'd0, seq[1]}, 64'd1);
    chk("arb_2_w", {62'd0, seq[2]}, 64'd2);
    chk("arb_3_r", {62'd0, seq[3]}, 64'd1);
    tick();
    tick();

    // Held response under backpressure, then back-to-back.
    rd_req_valid = 1'b1;
    rd_addr = 5'd7;
    rd_ready = 1'b0;
    @(negedge clk);
    chk("stall_acc", {63'd0, rd_req_ready}, 64'd1);
    tick();
    rd_addr = 5'd8;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_rdy", {63'd0, rd_req_ready}, 64'd0);
      chk("stall_vld", {63'd0, rd_valid}, 64'd1);
      chk("stall_data", rd_data, ref_mem[7]);
      tick();
    end
    rd_ready = 1'b1;
    @(negedge clk);
    chk("b2b_acc", {63'd0, rd_req_ready}, 64'd1);
    tick();
    rd_req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_vld", {63'd0, rd_valid}, 64'd1);
    chk("b2b_data", rd_data, ref_mem[8]);
    tick();
    @(negedge clk);
    chk("rsp_drop", {63'd0, rd_valid}, 64'd0);
    tick();

`ifdef HV_SRAM_CTRL_PERF_EN
    do_reset();
    for (int k = 0; k < 5; k++) do_write(5'(k), {$urandom, $urandom});
    for (int k = 0; k < 3; k++) do_read(5'(k));
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    wait_idle(nb);
    tick();
    chk("perf_wr", {32'd0, perf_wr_cnt}, 64'd5);
    chk("perf_rd", {32'd0, perf_rd_cnt}, 64'd3);
`endif

    // Randomised mixed traffic.
    for (int k = 0; k < 300; k++) begin
      wr_valid = ($urandom_range(0, 99) < 45);
      wr_addr = 5'($urandom);
      wr_data = {$urandom, $urandom};
      rd_req_valid = ($urandom_range(0, 99) < 50);
      rd_addr = 5'($urandom);
      rd_ready = ($urandom_range(0, 99) < 70);
      tick();
    end
    wr_valid = 1'b0;
    rd_req_valid = 1'b0;
    rd_ready = 1'b1;
    tick();
    tick();
    chk("q_drained", 64'(exp_q.size()), 64'd0);

    // Fill, then clear with requests pending and a re-trigger mid-sweep.
    for (int a = 0; a < 32; a++) do_write(5'(a), {$urandom, $urandom});
    clr_start = 1'b1;
    wr_valid = 1'b1;
    wr_addr = 5'd9;
    wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
    rd_req_valid = 1'b1;
    rd_addr = 5'd9;
    @(negedge clk);
    chk("clr_prio_wr", {63'd0, wr_ready}, 64'd0);
    chk("clr_prio_rd", {63'd0, rd_req_ready}, 64'd0);
    tick();
    clr_start = 1'b0;
    nb = 0;
    nd = 0;
    addr_at_done = -1;
    wr_hits = 0;
    rd_hits = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
      if (wr_ready) wr_hits++;
      if (rd_req_ready) rd_hits++;
      if (clr_done) begin
        nd++;
        addr_at_done = int'(sram_addr);
      end
      tick();
      clr_start = (nb == 5);
    end
    clr_start = 1'b0;
    wr_valid = 1'b0;
    rd_req_valid = 1'b0;
    chk("clr_busy_cycles", 64'(nb), 64'd32);
    chk("clr_done_pulses", 64'(nd), 64'd1);
    chk("clr_done_addr", 64'(addr_at_done), 64'd31);
    chk("clr_no_wr", 64'(wr_hits), 64'd0);
    chk("clr_no_rd", 64'(rd_hits), 64'd0);
    tick();
    tick();
    for (int a = 0; a < 32; a++) do_read(5'(a));
    tick();
    tick();
    chk("clr_q_drained", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a sweep.
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    hit10 = 1'b0;
    for (int k = 0; k < 40 && !hit10; k++) begin
      @(negedge clk);
      if (busy && sram_addr == 5'd10) hit10 = 1'b1;
      else tick();
    end
    chk("abort_reach10", {63'd0, hit10}, 64'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_csb", {63'd0, sram_csb}, 64'd1);
    chk("abort_web", {63'd0, sram_web}, 64'd1);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, clr_done}, 64'd0);
    chk("abort_addr", {59'd0, sram_addr}, 64'd0);
    chk("abort_rd_valid", {63'd0, rd_valid}, 64'd0);
    tick();
    chk("abort_held_csb", {63'd0, sram_csb}, 64'd1);
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
